// File: rtl/btn_cond.sv
// Push-button conditioner: per-channel 2-flop synchroniser, counted debounce,
// press/release pulses and hold-driven auto-repeat for active-low switches.
module btn_cond #(
    parameter int NUM_BTN  = 3,
    parameter int DEB_CNT  = 500000,
    parameter int LONG_CNT = 50000000,
    parameter int RPT_CNT  = 10000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] i_sw,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_rpt,
    output logic [NUM_BTN-1:0] o_long
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_REL
    } state_t;

    // Terminal counts; each counter is compared for equality so it never wraps.
    localparam logic [31:0] DEB_LIM  = 32'(DEB_CNT - 1);
    localparam logic [31:0] LONG_LIM = 32'(LONG_CNT - 1);
    localparam logic [31:0] RPT_LIM  = 32'(RPT_CNT - 1);

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;

    // Reset value of 1 means "released", so a button held through reset is
    // seen as a fresh press once reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= i_sw;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_t      state_q;
        logic [31:0] cnt_q;
        logic        level_q;
        logic        press_q;
        logic        release_q;
        logic        rpt_q;
        logic        long_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rpt_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rpt_q     <= 1'b0;
                case (state_q)
                    IDLE: begin
                        level_q <= 1'b0;
                        long_q  <= 1'b0;
                        if (!s2_q[g]) begin
                            state_q <= DEB_PRESS;
                            cnt_q   <= '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (s2_q[g]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LIM) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    HELD: begin
                        if (s2_q[g]) begin
                            state_q <= DEB_REL;
                            cnt_q   <= '0;
                        end else if (cnt_q == LONG_LIM) begin
                            state_q <= REPEAT;
                            cnt_q   <= '0;
                            rpt_q   <= 1'b1;
                            long_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    REPEAT: begin
                        if (s2_q[g]) begin
                            state_q <= DEB_REL;
                            cnt_q   <= '0;
                        end else if (cnt_q == RPT_LIM) begin
                            cnt_q <= '0;
                            rpt_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    DEB_REL: begin
                        // A bounce back to low resumes the hold with a fresh long timer.
                        if (!s2_q[g]) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            long_q  <= 1'b0;
                        end else if (cnt_q == DEB_LIM) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            long_q    <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        long_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_rpt[g]     = rpt_q;
        assign o_long[g]    = long_q;
    end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with short debounce/long/repeat windows;
// edge numbers count from the first clock edge that samples the new i_sw value.
module tb_btn_cond;

    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] i_sw;
    logic [NB-1:0] o_level;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_release;
    logic [NB-1:0] o_rpt;
    logic [NB-1:0] o_long;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    btn_cond #(
        .NUM_BTN (NB),
        .DEB_CNT (4),
        .LONG_CNT(20),
        .RPT_CNT (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sw     (i_sw),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_rpt    (o_rpt),
        .o_long   (o_long)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] sw);
        i_sw = sw;
    endtask

    // Outputs are sampled 1 ns after the active edge, where new inputs are also driven.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string name, input int e, input logic [NB-1:0] lv,
                            input logic [NB-1:0] pr, input logic [NB-1:0] rl,
                            input logic [NB-1:0] rp, input logic [NB-1:0] lg);
        checkOutput($sformatf("%s.e%0d.level", name, e), 32'(o_level), 32'(lv));
        checkOutput($sformatf("%s.e%0d.press", name, e), 32'(o_press), 32'(pr));
        checkOutput($sformatf("%s.e%0d.release", name, e), 32'(o_release), 32'(rl));
        checkOutput($sformatf("%s.e%0d.rpt", name, e), 32'(o_rpt), 32'(rp));
        checkOutput($sformatf("%s.e%0d.long", name, e), 32'(o_long), 32'(lg));
    endtask

    task automatic doReset(input string name);
        applyStimulus(3'b111);
        rst_n = 1'b0;
        repeat (3) stepEdge();
        checkAll(name, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
    endtask

    initial begin
        i_sw  = 3'b111;
        rst_n = 1'b1;
        #2;
        doReset("reset");

        // Clean press held for 10 samples, then released at edge 11.
        for (int e = 1; e <= 20; e++) begin
            applyStimulus((e <= 10) ? 3'b110 : 3'b111);
            stepEdge();
            checkAll("clean", e, (e >= 7 && e < 17) ? 3'b001 : 3'b000,
                     (e == 7) ? 3'b001 : 3'b000, (e == 17) ? 3'b001 : 3'b000,
                     3'b000, 3'b000);
        end

        // Three-sample glitch is rejected; a following clean press proves IDLE.
        doReset("reset2");
        for (int e = 1; e <= 15; e++) begin
            applyStimulus((e <= 3) ? 3'b110 : 3'b111);
            stepEdge();
            checkAll("glitch", e, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(3'b110);
            stepEdge();
            checkAll("postglitch", e, (e >= 7) ? 3'b001 : 3'b000,
                     (e == 7) ? 3'b001 : 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Hold 40 samples; the FSM sees low through edge 42, so repeats land at 27/32/37/42.
        doReset("reset3");
        for (int e = 1; e <= 50; e++) begin
            applyStimulus((e <= 40) ? 3'b110 : 3'b111);
            stepEdge();
            checkAll("long", e, (e >= 7 && e < 47) ? 3'b001 : 3'b000,
                     (e == 7) ? 3'b001 : 3'b000, (e == 47) ? 3'b001 : 3'b000,
                     (e == 27 || e == 32 || e == 37 || e == 42) ? 3'b001 : 3'b000,
                     (e >= 27 && e < 47) ? 3'b001 : 3'b000);
        end

        // Release bounce in REPEAT: high at edges 30-31, back in HELD at edge 34.
        doReset("reset4");
        for (int e = 1; e <= 60; e++) begin
            applyStimulus((e == 30 || e == 31) ? 3'b111 : 3'b110);
            stepEdge();
            checkAll("bounce", e, (e >= 7) ? 3'b001 : 3'b000,
                     (e == 7) ? 3'b001 : 3'b000, 3'b000,
                     (e == 27 || e == 54 || e == 59) ? 3'b001 : 3'b000,
                     ((e >= 27 && e <= 33) || e >= 54) ? 3'b001 : 3'b000);
        end

        // Channels 0 and 2 pressed together; channel 1 stays idle.
        doReset("reset5");
        for (int e = 1; e <= 20; e++) begin
            applyStimulus((e <= 10) ? 3'b010 : 3'b111);
            stepEdge();
            checkAll("simul", e, (e >= 7 && e < 17) ? 3'b101 : 3'b000,
                     (e == 7) ? 3'b101 : 3'b000, (e == 17) ? 3'b101 : 3'b000,
                     3'b000, 3'b000);
        end

        // Asynchronous reset during REPEAT, button kept held across reset.
        doReset("reset6");
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(3'b110);
            stepEdge();
        end
        checkAll("prereset", 30, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001);
        rst_n = 1'b0;
        #1;
        checkAll("asyncrst", 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        repeat (2) stepEdge();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            stepEdge();
            checkAll("afterrst", e, (e >= 7) ? 3'b001 : 3'b000,
                     (e == 7) ? 3'b001 : 3'b000, 3'b000, 3'b000, 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/btn_cond.md
Name: btn_cond

Overview:
Push-button conditioner that sits directly upstream of the clock controller and replaces its raw switch inputs. It does the following for each active-low push-button:
- synchronises the input to the 50 MHz system clock;
- debounces it with a counted stable window;
- emits single-cycle press and release pulses;
- emits auto-repeat pulses while the button is held.

The controller's mode, position and setup-increment logic consume these pulses as clean, clock-synchronous events.

Parameters:
NUM_BTN, 3, number of independent button channels.
DEB_CNT, 500000, stable-level window in clk cycles (10 ms at 50 MHz); must be >= 1.
LONG_CNT, 50000000, hold time before the first repeat pulse (1 s); must be >= 1.
RPT_CNT, 10000000, interval between subsequent repeat pulses (200 ms); must be >= 1.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset, asynchronous, active-low.
i_sw  input  NUM_BTN  raw buttons, active-low (0 = pressed), asynchronous to clk.
o_level  output  NUM_BTN  debounced level, 1 = pressed.
o_press  output  NUM_BTN  1-cycle pulse on debounced press.
o_release  output  NUM_BTN  1-cycle pulse on debounced release.
o_rpt  output  NUM_BTN  1-cycle auto-repeat pulse while held.
o_long  output  NUM_BTN  1 once a hold has exceeded LONG_CNT; stays 1 until released.

Behaviour:
- One clock (clk) and an asynchronous active-low reset (rst_n).
- Reset, asserted at any time including mid-debounce or mid-repeat:
  - sync flops go to 1 (released);
  - every FSM goes to IDLE and every counter to 0;
  - all outputs go to 0 immediately.
  - After rst_n rises, a button already held low is detected as a fresh press.
- Synchroniser: 2 flops per channel, s1 <= i_sw, s2 <= s1. The FSM uses s2 only.
- Each channel has its own 32-bit counter and FSM. Channels are fully independent, with no priority; simultaneous presses on several channels produce simultaneous pulses.
- FSM states are IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL:
  - IDLE: o_level=0. If s2==0: go to DEB_PRESS, cnt=0.
  - DEB_PRESS:
    - If s2==1: go to IDLE, with no output (a glitch shorter than the window is rejected).
    - Else if cnt==DEB_CNT-1: go to HELD, cnt=0, o_level=1, pulse o_press.
    - Else cnt++.
  - HELD:
    - If s2==1: go to DEB_REL, cnt=0.
    - Else if cnt==LONG_CNT-1: go to REPEAT, cnt=0, pulse o_rpt, o_long=1.
    - Else cnt++.
  - REPEAT:
    - If s2==1: go to DEB_REL, cnt=0.
    - Else if cnt==RPT_CNT-1: pulse o_rpt, cnt=0.
    - Else cnt++.
  - DEB_REL: o_level stays 1 and o_long holds its value.
    - If s2==0 (bounce): go to HELD, cnt=0, o_long=0. No second o_press; repeat timing restarts from LONG_CNT.
    - Else if cnt==DEB_CNT-1: go to IDLE, o_level=0, o_long=0, pulse o_release.
    - Else cnt++.
- All outputs are registered.
- Pulses are exactly 1 clk cycle wide. o_press and o_release are never high in the same cycle on one channel.
- Latency, with clean input edges and edges counted from the first clk edge at which i_sw is sampled low:
  - o_press is high in the cycle after edge DEB_CNT+3;
  - the first o_rpt comes LONG_CNT edges after o_press;
  - each later o_rpt comes RPT_CNT edges after the previous one.
- Release latency is symmetric: o_release follows DEB_CNT+3 edges after i_sw is first sampled high.
- Counter compare is equality against the parameter minus 1. The counter never exceeds its limit and never wraps.

Test Plan:
All scenarios use NUM_BTN=3, DEB_CNT=4, LONG_CNT=20, RPT_CNT=5, and edges counted from the first low sample.
1. Clean press held for 10 cycles, then released -> o_press pulse after edge 7; o_level 1 from edge 7; o_release pulse DEB_CNT+3 edges after the release; o_rpt never fires.
2. Glitch: i_sw[0] low for 3 cycles, then high -> no o_press, o_level stays 0, FSM back in IDLE.
3. Long hold for 40 cycles -> o_press at edge 7; o_rpt at edges 27, 32, 37; o_long=1 from edge 27 until o_release; o_long=0 after release.
4. Release bounce: in REPEAT, i_sw high for 2 cycles then low again -> no o_release, no extra o_press, o_long drops to 0, next o_rpt comes 20 edges after re-entry to HELD.
5. Simultaneous presses on i_sw[0] and i_sw[2] on the same edge -> o_press[0] and o_press[2] pulse on the same cycle; channel 1 stays idle.
6. Reset: rst_n pulled low during REPEAT -> all outputs 0 asynchronously; after rst_n rises with button still held -> o_press again DEB_CNT+3 edges later.
